bp_be_issue_scoreboard: RTL
===========================

// Module: bp_be_issue_scoreboard
// PURPOSE
//  Issue-stage sequencer for the RV64 integer datapath: decodes register usage from each
//  32-bit instruction (funct7|rs2|rs1|funct3|rd|opcode), tracks destination registers of
//  long-latency ops (loads, M-ext) still in flight, and holds issue on RAW/WAW hazards.
//  Serializes FENCE/SYSTEM by draining all pending writes first. Sits between fetch/decode
//  queue and register-file read stage; writeback ports clear the scoreboard.
// PARAMETERS
//  num_wb_p           2   number of independent writeback (completion) ports
//  stall_cnt_width_p  32  width of saturating hazard-stall cycle counter
// PORTS
//  clk_i             in   1             clock
//  reset_i           in   1             synchronous, active-high reset
//  instr_i           in   32            instruction; fields per RV64 base format
//  instr_v_i         in   1             instr_i valid
//  instr_ready_o     out  1             block accepts instr_i this cycle
//  dispatch_ready_i  in   1             downstream read stage can take issue_instr_o
//  issue_v_o         out  1             registered issue valid
//  issue_instr_o     out  32            registered issued instruction
//  wb_v_i            in   num_wb_p      per-port writeback valid
//  wb_rd_addr_i      in   5*num_wb_p    per-port writeback rd (port k at [5k+:5])
//  flush_i           in   1             kill in-flight state
//  pending_o         out  32            scoreboard bits, bit r = xr write outstanding
//  stall_cnt_o       out  stall_cnt_width_p  cycles with instr_v_i=1, ready=0, state RUN
// BEHAVIOUR
//  Reset (synchronous, active-high): pending_o=0, issue_v_o=0, issue_instr_o=0,
//   stall_cnt_o=0, FSM=RUN. Reset wins over every other input.
//  Decode (opcode[6:0]) -> uses rs1/rs2/rd:
//   OP 0110011, OP-32 0111011: rs1,rs2,rd | OP-IMM 0010011, OP-IMM-32 0011011, LOAD 0000011,
//   JALR 1100111: rs1,rd | STORE 0100011, BRANCH 1100011: rs1,rs2 | JAL 1101111, LUI
//   0110111, AUIPC 0010111: rd | MISC-MEM 0001111, SYSTEM 1110011: serializing | other: none.
//   Address 0 never counts as a use, never sets or tests pending.
//  Long-latency (sets pending[rd] on issue): LOAD; OP/OP-32 with funct7==7'b0000001.
//  Effective pending: eff = pending_o & ~wb_clr, wb_clr = OR of one-hot(wb_rd_addr) over
//   valid ports (same-cycle writeback bypass into hazard check).
//  Hazard: (rs1 used & eff[rs1]) | (rs2 used & eff[rs2]) | (rd used & eff[rd]) (WAW).
//  FSM RUN: instr_ready_o = dispatch_ready_i & ~hazard & ~serializing.
//   Serializing instr valid -> DRAIN (instr not accepted that cycle).
//  FSM DRAIN: instr_ready_o = dispatch_ready_i & (eff==0); on handshake -> RUN.
//  Handshake = instr_v_i & instr_ready_o. Next cycle issue_v_o=1, issue_instr_o=instr_i.
//   No handshake & dispatch_ready_i=1 -> issue_v_o=0. dispatch_ready_i=0 -> issue regs hold.
//   Latency instr_i -> issue_instr_o: exactly 1 cycle when no hazard.
//  Pending update: next = (pending & ~wb_clr) | set_rd; set wins over clear on same reg.
//   Writeback to an already clear bit: no-op. Two ports same rd: single clear.
//  flush_i: next cycle pending=0, issue_v_o=0, FSM=RUN; instr_ready_o=0 during flush
//   cycle; stall_cnt_o unaffected. Writebacks of flushed ops arriving later are no-ops.
//  stall_cnt_o: +1 per cycle with instr_v_i & ~instr_ready_o & FSM==RUN & ~flush_i;
//   saturates at all-ones, no wrap.
// TESTING
//  1 ld x5 (0x0002B283... any LOAD rd=5) then add x6,x5,x1 -> add stalled, pending_o[5]=1,
//    stall_cnt increments each cycle; wb_v_i[0]=1,rd=5 -> add issues same cycle, 1 cycle later.
//  2 mul x7 (funct7=0000001) then add x7,x1,x2 -> WAW stall until wb rd=7; add x7 w/o mul
//    back-to-back -> no stall, pending_o stays 0.
//  3 fence (opcode 0001111) with pending_o=0x0000_0030 -> FSM DRAIN, ready=0; clear x4 then
//    x5 -> fence issues cycle eff==0, FSM returns RUN.
//  4 flush_i with pending_o=0xFFFF_FFFE and FSM DRAIN -> next cycle pending_o=0, issue_v_o=0,
//    RUN; stale wb rd=3 afterward -> no change.
//  5 ld x0 and add x1,x0,x0 back-to-back -> no pending, no stall; dispatch_ready_i=0 for 3
//    cycles -> issue_instr_o held, instr_ready_o=0, stall_cnt unchanged? no: counts.
//  6 Force stall_cnt to all-ones (stall_cnt_width_p=4, 20 stall cycles) -> holds 4'hF; reset
//    mid-drain -> all outputs 0, FSM RUN next cycle.

Source files
------------

// File: rtl/bp_be_issue_scoreboard.sv
// bp_be_issue_scoreboard
//   Issue-stage sequencer for the RV64 integer datapath. Decodes register
//   usage of the incoming instruction, tracks destination registers of
//   long-latency ops (loads, M-extension) still in flight, holds issue on
//   RAW/WAW hazards and drains all outstanding writes before letting a
//   FENCE/SYSTEM instruction through.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal issue, hazard-checked per instruction
//   DRAIN | serializing instr waiting for every pending write to retire
//
// Ports
//   clk_i, reset_i     clock, synchronous active-high reset
//   instr_i/instr_v_i  instruction from decode queue, valid
//   instr_ready_o      instruction accepted this cycle (combinational)
//   dispatch_ready_i   read stage can take the issue register
//   issue_v_o          registered issue valid
//   issue_instr_o      registered issued instruction
//   wb_v_i             per-port writeback valid
//   wb_rd_addr_i       per-port writeback rd, port k at [5k+:5]
//   flush_i            drop all in-flight tracking
//   pending_o          bit r set while a write to xr is outstanding
//   stall_cnt_o        saturating count of hazard-stalled cycles in RUN
module bp_be_issue_scoreboard #(
  parameter int num_wb_p          = 2,
  parameter int stall_cnt_width_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [31:0]                  instr_i,
  input  logic                         instr_v_i,
  output logic                         instr_ready_o,
  input  logic                         dispatch_ready_i,
  output logic                         issue_v_o,
  output logic [31:0]                  issue_instr_o,
  input  logic [num_wb_p-1:0]          wb_v_i,
  input  logic [5*num_wb_p-1:0]        wb_rd_addr_i,
  input  logic                         flush_i,
  output logic [31:0]                  pending_o,
  output logic [stall_cnt_width_p-1:0] stall_cnt_o
);

  localparam logic [6:0] opc_op       = 7'b0110011;
  localparam logic [6:0] opc_op_32    = 7'b0111011;
  localparam logic [6:0] opc_op_imm   = 7'b0010011;
  localparam logic [6:0] opc_op_imm32 = 7'b0011011;
  localparam logic [6:0] opc_load     = 7'b0000011;
  localparam logic [6:0] opc_jalr     = 7'b1100111;
  localparam logic [6:0] opc_store    = 7'b0100011;
  localparam logic [6:0] opc_branch   = 7'b1100011;
  localparam logic [6:0] opc_jal      = 7'b1101111;
  localparam logic [6:0] opc_lui      = 7'b0110111;
  localparam logic [6:0] opc_auipc    = 7'b0010111;
  localparam logic [6:0] opc_misc_mem = 7'b0001111;
  localparam logic [6:0] opc_system   = 7'b1110011;
  localparam logic [6:0] funct7_mext  = 7'b0000001;

  typedef enum logic [0:0] {
    st_run   = 1'b0,
    st_drain = 1'b1
  } state_e;

  state_e state_r;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic [6:0] funct7;
  logic       use_rs1, use_rs2, use_rd, serial, long_lat;
  logic [31:0] wb_clr, eff, set_vec;
  logic       hazard, handshake, stall_inc;
  logic       unused_funct3;

  assign opcode        = instr_i[6:0];
  assign rd            = instr_i[11:7];
  assign rs1           = instr_i[19:15];
  assign rs2           = instr_i[24:20];
  assign funct7        = instr_i[31:25];
  assign unused_funct3 = ^instr_i[14:12];

  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    serial   = 1'b0;
    long_lat = 1'b0;
    case (opcode)
      opc_op, opc_op_32: begin
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        use_rd   = 1'b1;
        long_lat = (funct7 == funct7_mext);
      end
      opc_op_imm, opc_op_imm32, opc_jalr: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      opc_load: begin
        use_rs1  = 1'b1;
        use_rd   = 1'b1;
        long_lat = 1'b1;
      end
      opc_store, opc_branch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      opc_jal, opc_lui, opc_auipc: use_rd = 1'b1;
      opc_misc_mem, opc_system:    serial = 1'b1;
      default: ;
    endcase
  end

  // Writebacks landing this cycle are bypassed into the hazard check.
  always_comb begin
    wb_clr = '0;
    for (int k = 0; k < num_wb_p; k++) begin
      if (wb_v_i[k]) wb_clr[wb_rd_addr_i[5*k+:5]] = 1'b1;
    end
    wb_clr[0] = 1'b0;
  end

  assign eff = pending_o & ~wb_clr;

  // x0 never holds pending, so eff[0] is always 0 and needs no extra check.
  assign hazard = (use_rs1 & eff[rs1]) | (use_rs2 & eff[rs2]) | (use_rd & eff[rd]);

  always_comb begin
    instr_ready_o = 1'b0;
    if (!flush_i) begin
      if (state_r == st_run) instr_ready_o = dispatch_ready_i & ~hazard & ~serial;
      else                   instr_ready_o = dispatch_ready_i & (eff == '0);
    end
  end

  assign handshake = instr_v_i & instr_ready_o;
  assign stall_inc = instr_v_i & ~instr_ready_o & (state_r == st_run) & ~flush_i;

  always_comb begin
    set_vec = '0;
    if (handshake && long_lat && (rd != 5'd0)) set_vec[rd] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= st_run;
      pending_o     <= '0;
      issue_v_o     <= 1'b0;
      issue_instr_o <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (flush_i) begin
        state_r   <= st_run;
        pending_o <= '0;
        issue_v_o <= 1'b0;
      end else begin
        // Set after clear so a new producer wins over a same-cycle writeback.
        pending_o <= (pending_o & ~wb_clr) | set_vec;
        if (dispatch_ready_i) begin
          issue_v_o <= handshake;
          if (handshake) issue_instr_o <= instr_i;
        end
        case (state_r)
          st_run:   if (instr_v_i && serial) state_r <= st_drain;
          st_drain: if (handshake)           state_r <= st_run;
          default:                           state_r <= st_run;
        endcase
      end
      if (stall_inc && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule
